uart_rx_cfg: RTL and testbench

Configurable UART receiver, the parametrised successor to the fixed 8N1 receiver. It supports 5–8 data bits, none/odd/even parity and 1 or 2 stop bits. It adds glitch-filtered 3-sample majority voting, parity and framing error flags, and break detection. It sits between the board RX pin and byte-level consumers (command parser, loopback, FIFO), in the single system clock domain.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_cfg_if.sv | 22 ++
 rtl/uart_rx_sync_vote.sv | 25 ++
 rtl/uart_rx_cfg.sv | 170 +++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver/transmitter state encoding, counter sizing.
// Used by the configurable RX and, later, the configurable TX.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_PARITY     = 3'd3,
        ST_STOP       = 3'd4,
        ST_BREAK_WAIT = 3'd5
    } uart_state_t;

    // Bit-period counter only ever holds 0..clks-1.
    function automatic int cnt_width(input int clks);
        return (clks <= 2) ? 1 : $clog2(clks);
    endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Serial line in, received byte plus status flags out.
// The slave modport is the receiver; the master modport is whoever drives the line and consumes bytes.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_Rx_Serial;
    logic                 o_Rx_DV;
    logic [DATA_BITS-1:0] o_Rx_Byte;
    logic                 o_Parity_Err;
    logic                 o_Frame_Err;
    logic                 o_Break;

    modport master (
        output i_Rx_Serial,
        input  o_Rx_DV, o_Rx_Byte, o_Parity_Err, o_Frame_Err, o_Break
    );

    modport slave (
        input  i_Rx_Serial,
        output o_Rx_DV, o_Rx_Byte, o_Parity_Err, o_Frame_Err, o_Break
    );
endinterface

// File: rtl/uart_rx_sync_vote.sv
// Two-flop synchroniser followed by a 3-tap majority vote; everything resets to line-idle (1).
// A single-cycle low on the synchronised line can never pull the voted output low.
module uart_rx_sync_vote (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Rx_Serial,
    output logic voted
);

    logic [1:0] sync;
    logic [2:0] taps;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            sync <= 2'b11;
            taps <= 3'b111;
        end else begin
            sync <= {sync[0], i_Rx_Serial};
            taps <= {taps[1:0], sync[1]};
        end
    end

    assign voted = (taps[0] & taps[1]) | (taps[0] & taps[2]) | (taps[1] & taps[2]);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (5-8 data bits, none/odd/even parity, 1-2 stop bits) with break detection.
// Byte and flags update together with a one-cycle o_Rx_DV pulse after the final stop-bit sample.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1
) (
    input logic          i_Clock,
    input logic          i_Reset,
    uart_rx_cfg_if.slave rx
);

    localparam int                CNT_W    = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);
    localparam logic             STP_LAST = 1'(STOP_BITS - 1);

    uart_state_t          state, state_nxt;
    logic                 rx_v;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_acc, par_bit, par_err, frame_acc;
    logic                 cnt_clr, cnt_inc, shift_en, par_en, stop_en, done, brk, brk_now;
    logic                 dv_r, perr_r, ferr_r, brk_r;
    logic [DATA_BITS-1:0] byte_r;

    uart_rx_sync_vote u_sync_vote (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .i_Rx_Serial (rx.i_Rx_Serial),
        .voted       (rx_v)
    );

    // Break: everything from data through the first stop bit read as 0.
    assign brk_now = (shreg == '0) && ((PARITY == PAR_NONE) || !par_bit) && !rx_v;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        stop_en   = 1'b0;
        done      = 1'b0;
        brk       = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (!rx_v) state_nxt = ST_START;
            end
            ST_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_clr   = 1'b1;
                    state_nxt = rx_v ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == IDX_LAST)
                        state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_PARITY: begin
                if (cnt == CNT_LAST) begin
                    cnt_clr   = 1'b1;
                    par_en    = 1'b1;
                    state_nxt = ST_STOP;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_clr = 1'b1;
                    stop_en = 1'b1;
                    // Leave at mid-stop so a back-to-back start edge is not missed.
                    if (!stop_idx && brk_now) begin
                        done      = 1'b1;
                        brk       = 1'b1;
                        state_nxt = ST_BREAK_WAIT;
                    end else if (stop_idx == STP_LAST) begin
                        done      = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_BREAK_WAIT: begin
                cnt_clr = 1'b1;
                if (rx_v) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            cnt       <= '0;
            bit_idx   <= 3'd0;
            stop_idx  <= 1'b0;
            shreg     <= '0;
            par_acc   <= 1'b0;
            par_bit   <= 1'b0;
            par_err   <= 1'b0;
            frame_acc <= 1'b0;
            dv_r      <= 1'b0;
            byte_r    <= '0;
            perr_r    <= 1'b0;
            ferr_r    <= 1'b0;
            brk_r     <= 1'b0;
        end else begin
            dv_r <= done;
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 1'b1;
            if (state == ST_IDLE) begin
                bit_idx   <= 3'd0;
                stop_idx  <= 1'b0;
                par_acc   <= 1'b0;
                par_bit   <= 1'b0;
                par_err   <= 1'b0;
                frame_acc <= 1'b0;
            end else begin
                if (shift_en) begin
                    shreg   <= {rx_v, shreg[DATA_BITS-1:1]};
                    par_acc <= par_acc ^ rx_v;
                    bit_idx <= bit_idx + 3'd1;
                end
                if (par_en) begin
                    par_bit <= rx_v;
                    par_err <= (PARITY == PAR_ODD) ? ~(par_acc ^ rx_v) : (par_acc ^ rx_v);
                end
                if (stop_en) begin
                    stop_idx <= stop_idx + 1'b1;
                    if (!rx_v) frame_acc <= 1'b1;
                end
            end
            if (done) begin
                byte_r <= brk ? '0 : shreg;
                perr_r <= par_err;
                ferr_r <= frame_acc | ~rx_v;
                brk_r  <= brk;
            end
        end
    end

    assign rx.o_Rx_DV      = dv_r;
    assign rx.o_Rx_Byte    = byte_r;
    assign rx.o_Parity_Err = perr_r;
    assign rx.o_Frame_Err  = ferr_r;
    assign rx.o_Break      = brk_r;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three receivers (8N1, 7E1, 8O2, 8 clocks/bit) driven by frame-level stimulus.
module tb_uart_rx_cfg;
    import uart_pkg::*;

    typedef struct {
        logic [7:0] b;
        logic       pe;
        logic       fe;
        logic       bk;
        int         cyc;
    } rec_t;

    localparam int BIT_T = 800;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    rec_t dvq[3][$];

    int cfg_db[3] = '{8, 7, 8};
    int cfg_pm[3] = '{PAR_NONE, PAR_EVEN, PAR_ODD};
    int cfg_ns[3] = '{1, 1, 2};

    always #50 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_cfg_if #(.DATA_BITS(8)) if0 ();
    uart_rx_cfg_if #(.DATA_BITS(7)) if1 ();
    uart_rx_cfg_if #(.DATA_BITS(8)) if2 ();

    uart_rx_cfg #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1))
        u_8n1 (.i_Clock(clk), .i_Reset(rst), .rx(if0.slave));
    uart_rx_cfg #(.CLKS_PER_BIT(8), .DATA_BITS(7), .PARITY(PAR_EVEN), .STOP_BITS(1))
        u_7e1 (.i_Clock(clk), .i_Reset(rst), .rx(if1.slave));
    uart_rx_cfg #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY(PAR_ODD), .STOP_BITS(2))
        u_8o2 (.i_Clock(clk), .i_Reset(rst), .rx(if2.slave));

    always @(negedge clk) if (if0.o_Rx_DV === 1'b1)
        dvq[0].push_back('{if0.o_Rx_Byte, if0.o_Parity_Err, if0.o_Frame_Err, if0.o_Break, cyc});
    always @(negedge clk) if (if1.o_Rx_DV === 1'b1)
        dvq[1].push_back('{8'(if1.o_Rx_Byte), if1.o_Parity_Err, if1.o_Frame_Err, if1.o_Break, cyc});
    always @(negedge clk) if (if2.o_Rx_DV === 1'b1)
        dvq[2].push_back('{if2.o_Rx_Byte, if2.o_Parity_Err, if2.o_Frame_Err, if2.o_Break, cyc});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_line(input int d, input logic v);
        case (d)
            0:       if0.i_Rx_Serial = v;
            1:       if1.i_Rx_Serial = v;
            default: if2.i_Rx_Serial = v;
        endcase
    endtask

    function automatic logic [7:0] mask_of(input int dbits);
        return 8'((1 << dbits) - 1);
    endfunction

    // Parity bit a correct transmitter would send, optionally inverted.
    function automatic logic par_for(input int data, input int dbits, input int pm, input logic flip);
        int ones;
        ones = $countones(8'(data) & mask_of(dbits));
        if (pm == PAR_NONE) return 1'b0;
        return ((pm == PAR_ODD) ? ((ones % 2) == 0) : ((ones % 2) == 1)) ^ flip;
    endfunction

    // What the receiver must report for a frame with these fields.
    function automatic rec_t model(input int data, input int dbits, input int pm, input logic pbit,
                                   input logic s0, input logic s1, input int ns);
        rec_t r;
        logic [7:0] d;
        int tot;
        d     = 8'(data) & mask_of(dbits);
        tot   = $countones(d) + int'(pbit);
        r.bk  = (d == 8'd0) && (pm == PAR_NONE || !pbit) && !s0;
        r.pe  = (pm == PAR_NONE) ? 1'b0 : (pm == PAR_ODD) ? ((tot % 2) != 1) : ((tot % 2) != 0);
        r.fe  = r.bk || !s0 || (ns == 2 && !s1);
        r.b   = r.bk ? 8'd0 : d;
        r.cyc = 0;
        return r;
    endfunction

    task automatic send_frame(input int d, input int data, input logic pbit, input logic s0,
                              input logic s1, input int bit_t, output int fall_cyc);
        logic [7:0] dat;
        dat = 8'(data);
        fall_cyc = cyc;
        set_line(d, 1'b0);
        #(bit_t);
        for (int i = 0; i < cfg_db[d]; i++) begin
            set_line(d, dat[i]);
            #(bit_t);
        end
        if (cfg_pm[d] != PAR_NONE) begin
            set_line(d, pbit);
            #(bit_t);
        end
        set_line(d, s0);
        #(bit_t);
        if (cfg_ns[d] == 2) begin
            set_line(d, s1);
            #(bit_t);
        end
        set_line(d, 1'b1);
    endtask

    task automatic expect_dv(input int d, input rec_t e, input string tag, output int dv_cyc);
        rec_t r;
        int n;
        n = 0;
        dv_cyc = -1;
        while (dvq[d].size() == 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " dv_seen"}, 32'(dvq[d].size() != 0), 32'd1);
        if (dvq[d].size() != 0) begin
            r = dvq[d].pop_front();
            chk({tag, " byte"}, 32'(r.b), 32'(e.b));
            chk({tag, " parity_err"}, 32'(r.pe), 32'(e.pe));
            chk({tag, " frame_err"}, 32'(r.fe), 32'(e.fe));
            chk({tag, " break"}, 32'(r.bk), 32'(e.bk));
            dv_cyc = r.cyc;
        end
    endtask

    task automatic send_and_check(input int d, input int data, input logic flip, input string tag);
        logic pb;
        int fc, dc;
        pb = par_for(data, cfg_db[d], cfg_pm[d], flip);
        send_frame(d, data, pb, 1'b1, 1'b1, BIT_T, fc);
        expect_dv(d, model(data, cfg_db[d], cfg_pm[d], pb, 1'b1, 1'b1, cfg_ns[d]), tag, dc);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        int fc, dc, lat;
        logic pb;
        rec_t e;

        if0.i_Rx_Serial = 1'b1;
        if1.i_Rx_Serial = 1'b1;
        if2.i_Rx_Serial = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset dv", 32'(if0.o_Rx_DV), 32'd0);
        chk("reset byte", 32'(if0.o_Rx_Byte), 32'd0);
        chk("reset flags", 32'({if0.o_Parity_Err, if0.o_Frame_Err, if0.o_Break}), 32'd0);
        chk("reset byte7", 32'(if1.o_Rx_Byte), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // 8N1 basic, with first-pulse latency measured from the line's falling edge
        send_frame(0, 8'h37, 1'b0, 1'b1, 1'b1, BIT_T, fc);
        expect_dv(0, model(8'h37, 8, PAR_NONE, 1'b0, 1'b1, 1'b1, 1), "8n1_37", dc);
        lat = dc - fc;
        chk("8n1 latency in 80..83", 32'(lat >= 80 && lat <= 83), 32'd1);
        repeat (20) @(negedge clk);
        chk("8n1 single dv", 32'(dvq[0].size()), 32'd0);
        chk("8n1 byte held", 32'(if0.o_Rx_Byte), 32'h37);

        // 7E1 good then bad parity
        send_and_check(1, 8'h5A, 1'b0, "7e1_good");
        repeat (16) @(negedge clk);
        send_and_check(1, 8'h5A, 1'b1, "7e1_bad");
        repeat (16) @(negedge clk);

        // 8O2 with the second stop bit low; a trailing low line may start a junk frame, discarded
        pb = par_for(8'h96, 8, PAR_ODD, 1'b0);
        send_frame(2, 8'h96, pb, 1'b1, 1'b0, BIT_T, fc);
        expect_dv(2, model(8'h96, 8, PAR_ODD, pb, 1'b1, 1'b0, 2), "8o2_ferr", dc);
        repeat (200) @(negedge clk);
        dvq[2].delete();

        // Break: 20 bit times low gives exactly one frame
        set_line(0, 1'b0);
        repeat (20 * 8) @(negedge clk);
        set_line(0, 1'b1);
        e = model(0, 8, PAR_NONE, 1'b0, 1'b0, 1'b0, 1);
        expect_dv(0, e, "break", dc);
        repeat (30) @(negedge clk);
        chk("break single dv", 32'(dvq[0].size()), 32'd0);
        send_and_check(0, 8'hA5, 1'b0, "after_break");
        repeat (16) @(negedge clk);

        // One-clock glitch, then a two-clock false start, then a real frame
        set_line(0, 1'b0);
        @(negedge clk);
        set_line(0, 1'b1);
        repeat (200) @(negedge clk);
        chk("glitch no dv", 32'(dvq[0].size()), 32'd0);
        set_line(0, 1'b0);
        repeat (2) @(negedge clk);
        set_line(0, 1'b1);
        repeat (200) @(negedge clk);
        chk("false start no dv", 32'(dvq[0].size()), 32'd0);
        send_and_check(0, 8'h5C, 1'b0, "after_glitch");
        repeat (16) @(negedge clk);

        // Back-to-back, no idle, transmitter 2% fast (784 vs 800 time units per bit)
        send_frame(0, 8'h00, 1'b0, 1'b1, 1'b1, 784, fc);
        send_frame(0, 8'hFF, 1'b0, 1'b1, 1'b1, 784, fc);
        send_frame(0, 8'h81, 1'b0, 1'b1, 1'b1, 784, fc);
        expect_dv(0, model(8'h00, 8, PAR_NONE, 1'b0, 1'b1, 1'b1, 1), "b2b_00", dc);
        expect_dv(0, model(8'hFF, 8, PAR_NONE, 1'b0, 1'b1, 1'b1, 1), "b2b_ff", dc);
        expect_dv(0, model(8'h81, 8, PAR_NONE, 1'b0, 1'b1, 1'b1, 1), "b2b_81", dc);
        repeat (16) @(negedge clk);

        // Reset in the middle of the data bits
        set_line(0, 1'b0);
        repeat (8) @(negedge clk);
        set_line(0, 1'b1);
        repeat (16) @(negedge clk);
        set_line(0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midreset byte", 32'(if0.o_Rx_Byte), 32'd0);
        chk("midreset flags", 32'({if0.o_Rx_DV, if0.o_Parity_Err, if0.o_Frame_Err, if0.o_Break}), 32'd0);
        repeat (2) @(negedge clk);
        set_line(0, 1'b1);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("midreset no dv", 32'(dvq[0].size()), 32'd0);
        send_and_check(0, 8'hC3, 1'b0, "after_reset");
        repeat (16) @(negedge clk);

        // Random frames on every configuration
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 6; k++) begin
                logic flip;
                int data;
                data = int'($urandom_range(0, 255));
                flip = (cfg_pm[d] != PAR_NONE) ? 1'($urandom_range(0, 1)) : 1'b0;
                repeat ($urandom_range(0, 24)) @(negedge clk);
                send_and_check(d, data, flip, $sformatf("rand d%0d #%0d", d, k));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
